// File: rtl/writeback_queue_pkg.sv
// Shared types and constants for the writeback stage.
// Load funct3 encodings, datapath widths and the queue entry layout.
package writeback_queue_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Producer-side handshakes into the writeback queue.
// The ALU path and the load path each carry a valid/ready pair.
interface writeback_queue_if;
  import writeback_queue_pkg::*;

  logic            alu_valid;
  logic            alu_ready;
  reg_addr_t       alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            mem_valid;
  logic            mem_ready;
  reg_addr_t       mem_rd;
  logic [63:0]     mem_data;
  logic [2:0]      mem_funct3;
  logic [2:0]      mem_addr_lo;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output mem_funct3, mem_addr_lo,
    input  alu_ready, mem_ready
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  mem_funct3, mem_addr_lo,
    output alu_ready, mem_ready
  );

endinterface

// File: rtl/writeback_queue_load_extend.sv
// Load data alignment and sign/zero extension.
// The offset is masked to natural alignment for each access size.
module load_extend
  import writeback_queue_pkg::*;
(
  input  logic [63:0]     data,
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr_lo,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] w;

  assign b = data[{addr_lo, 3'b000} +: 8];
  assign h = data[{addr_lo[2:1], 4'b0000} +: 16];
  assign w = data[{addr_lo[2], 5'b00000} +: 32];

  always_comb begin
    ext = '0;
    unique case (1'b1)
      (funct3 == F3_LB):  ext = {{(XLEN-8){b[7]}}, b};
      (funct3 == F3_LH):  ext = {{(XLEN-16){h[15]}}, h};
      (funct3 == F3_LW):  ext = {{(XLEN-32){w[31]}}, w};
      (funct3 == F3_LD):  ext = data;
      (funct3 == F3_LBU): ext = {{(XLEN-8){1'b0}}, b};
      (funct3 == F3_LHU): ext = {{(XLEN-16){1'b0}}, h};
      (funct3 == F3_LWU): ext = {{(XLEN-32){1'b0}}, w};
      default:            ext = '0;
    endcase
  end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback FIFO feeding the register file write port.
// Merges ALU and load results, drains one per cycle, flags pending rds.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  writeback_queue_if.slave   prod,
  output logic               reg_write,
  output reg_addr_t          rd_addr,
  output logic [XLEN-1:0]    rd_data,
  input  reg_addr_t          rs1_addr,
  input  reg_addr_t          rs2_addr,
  output logic               rs1_pending,
  output logic               rs2_pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;

  logic            rdy, deq;
  logic            mem_st, alu_st;
  logic [XLEN-1:0] mem_ext;
  logic [PW-1:0]   rd_ptr_n, alu_slot;
  logic [CW-1:0]   count_n;
  wb_entry_t       mem_ent, alu_ent, head_n;
  logic            head_vld_n;

  load_extend u_ext (
    .data    (prod.mem_data),
    .funct3  (prod.mem_funct3),
    .addr_lo (prod.mem_addr_lo),
    .ext     (mem_ext)
  );

  // No credit for a same-cycle pop: room for two is judged on the flop.
  assign rdy            = !rst && (count <= CW'(DEPTH - 2));
  assign prod.alu_ready = rdy;
  assign prod.mem_ready = rdy;

  assign mem_st  = prod.mem_valid && rdy && (prod.mem_rd != '0);
  assign alu_st  = prod.alu_valid && rdy && (prod.alu_rd != '0);
  assign mem_ent = '{rd: prod.mem_rd, data: mem_ext};
  assign alu_ent = '{rd: prod.alu_rd, data: prod.alu_data};

  assign deq      = (count != '0);
  assign rd_ptr_n = rd_ptr + PW'(deq);
  assign alu_slot = wr_ptr + PW'(mem_st);
  assign count_n  = count + CW'(mem_st) + CW'(alu_st) - CW'(deq);

  // Next head: a surviving old entry, else the oldest one arriving now.
  always_comb begin
    head_n     = '0;
    head_vld_n = 1'b0;
    if (count > CW'(deq)) begin
      head_n     = q[rd_ptr_n];
      head_vld_n = 1'b1;
    end else if (mem_st) begin
      head_n     = mem_ent;
      head_vld_n = 1'b1;
    end else if (alu_st) begin
      head_n     = alu_ent;
      head_vld_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_st) q[wr_ptr]   <= mem_ent;
    if (alu_st) q[alu_slot] <= alu_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      vld       <= '0;
      reg_write <= 1'b0;
      rd_addr   <= '0;
      rd_data   <= '0;
    end else begin
      count_ovf: assert (count_n <= CW'(DEPTH));
      if (deq)    vld[rd_ptr]   <= 1'b0;
      if (mem_st) vld[wr_ptr]   <= 1'b1;
      if (alu_st) vld[alu_slot] <= 1'b1;
      rd_ptr    <= rd_ptr_n;
      wr_ptr    <= wr_ptr + PW'(mem_st) + PW'(alu_st);
      count     <= count_n;
      reg_write <= head_vld_n;
      rd_addr   <= head_n.rd;
      rd_data   <= head_n.data;
    end
  end

  always_comb begin
    rs1_pending = 1'b0;
    rs2_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && q[i].rd == rs1_addr) rs1_pending = 1'b1;
      if (vld[i] && q[i].rd == rs2_addr) rs2_pending = 1'b1;
    end
    rs1_pending = rs1_pending && !rst && (rs1_addr != '0);
    rs2_pending = rs2_pending && !rst && (rs2_addr != '0);
  end

endmodule
